// File: rtl/enigma_feeder_if.sv
// ----------------------------------------------------------------------------
// enigma_feeder_if
//   Upstream symbol stream into the enigma feeder.
//   Signals:
//     in_valid : source has a symbol on in_data
//     in_ready : feeder accepts in_data this cycle
//     in_data  : rotor entry (table load) or plaintext symbol (crypt)
//     in_last  : marks the final plaintext symbol of a message
//   Modports:
//     master : symbol source (DMA / UART front end)
//     slave  : the feeder
// ----------------------------------------------------------------------------
interface enigma_feeder_if #(
  parameter int DATA_W = 6
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface : enigma_feeder_if

// File: rtl/enigma_feeder.sv
// ----------------------------------------------------------------------------
// enigma_feeder
//   Upstream sequencer for the enigma core. It turns a single valid/ready
//   symbol stream into the core's protocol:
//     1. TABLE_DEPTH rotor entries (load=1, load_idx, code_out)
//     2. GAP_CYCLES cycles with load=0 and encrypt=0
//     3. plaintext symbols (encrypt=1, code_out) until in_last
//   A session starts with a start pulse in IDLE and ends with a one-cycle
//   done pulse.
//
// Ports:
//   clk        : clock, rising edge
//   srst       : synchronous reset, active high, dominates everything
//   start      : one-cycle session start, honoured only in IDLE
//   mode_in    : crypt mode, captured on the accepted start
//   up         : upstream stream (enigma_feeder_if.slave)
//   load       : core table-load strobe          (registered)
//   load_idx   : core table index                (registered)
//   code_out   : core code_in                    (registered)
//   encrypt    : core encrypt strobe             (registered)
//   crypt_mode : core crypt mode, held per session (registered)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at end of session
//   perm_err   : sticky rotor-table permutation error
//
// Build option:
//   ROTOR_CHECK_EN : when defined, each loaded table is checked for being a
//                    permutation of 0..TABLE_DEPTH-1 (duplicate entry or a
//                    missing value raises perm_err). When undefined perm_err
//                    is tied low.
// ----------------------------------------------------------------------------
module enigma_feeder #(
  parameter int TABLE_DEPTH = 64,
  parameter int DATA_W      = 6,
  parameter int IDX_W       = 8,
  parameter int GAP_CYCLES  = 1    // legal range 1..15
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic              mode_in,
  enigma_feeder_if.slave    up,
  output logic              load,
  output logic [IDX_W-1:0]  load_idx,
  output logic [DATA_W-1:0] code_out,
  output logic              encrypt,
  output logic              crypt_mode,
  output logic              busy,
  output logic              done,
  output logic              perm_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_DEPTH - 1);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_CRYPT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_cnt;
  logic [3:0]       gap_cnt;

  logic ready_c;
  logic start_acc;
  logic load_beat;
  logic crypt_beat;

  // --------------------------------------------------------------------------
  // Next-state and handshake decode
  // --------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ready_c    = 1'b0;
    start_acc  = 1'b0;
    load_beat  = 1'b0;
    crypt_beat = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        ready_c   = 1'b1;
        load_beat = up.in_valid;
        // in_last has no meaning while the table is loading.
        if (up.in_valid && (idx_cnt == LAST_IDX)) begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = S_CRYPT;
        end
      end

      S_CRYPT: begin
        ready_c    = 1'b1;
        crypt_beat = up.in_valid;
        if (up.in_valid && up.in_last) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Ready depends on state only, never on in_valid.
  assign up.in_ready = ready_c;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

  // --------------------------------------------------------------------------
  // State, counters and registered core-facing outputs
  // --------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= S_IDLE;
      idx_cnt    <= '0;
      gap_cnt    <= '0;
      load       <= 1'b0;
      load_idx   <= '0;
      code_out   <= '0;
      encrypt    <= 1'b0;
      crypt_mode <= 1'b0;
    end else begin
      state_q <= state_d;

      // Strobes are high only in the cycle after an accepted beat.
      load    <= load_beat;
      encrypt <= crypt_beat;

      if (start_acc) begin
        crypt_mode <= mode_in;
        idx_cnt    <= '0;
        gap_cnt    <= '0;
      end

      // idx_cnt tops out at TABLE_DEPTH because LOAD exits on the last entry.
      if (load_beat) begin
        load_idx <= idx_cnt;
        code_out <= up.in_data;
        idx_cnt  <= idx_cnt + 1'b1;
      end

      // Without a beat code_out holds; the core only steps on encrypt=1.
      if (crypt_beat) begin
        code_out <= up.in_data;
      end

      if (state_q == S_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional rotor-table permutation check (report only)
  // --------------------------------------------------------------------------
`ifdef ROTOR_CHECK_EN
  logic [TABLE_DEPTH-1:0] seen_q;
  logic [TABLE_DEPTH-1:0] seen_set;
  logic                   perm_q;

  // One-hot of the incoming entry; values outside the table shift out to
  // zero and are then caught by the missing-entry test at GAP entry.
  assign seen_set = {{(TABLE_DEPTH-1){1'b0}}, 1'b1} << up.in_data;

  // NOTE: seen_q is an ordinary flop vector, not a memory, so it is reset
  // explicitly and cleared again on every accepted start.
  always_ff @(posedge clk) begin
    if (srst) begin
      seen_q <= '0;
      perm_q <= 1'b0;
    end else if (start_acc) begin
      seen_q <= '0;
      perm_q <= 1'b0;
    end else if (load_beat) begin
      seen_q <= seen_q | seen_set;
      if ((seen_q & seen_set) != '0) begin
        perm_q <= 1'b1;
      end
      // The final entry is folded in before looking for holes.
      if ((state_d == S_GAP) && !(&(seen_q | seen_set))) begin
        perm_q <= 1'b1;
      end
    end
  end

  assign perm_err = perm_q;
`else
  assign perm_err = 1'b0;
`endif

endmodule : enigma_feeder

// File: tb/tb_enigma_feeder.sv
// ----------------------------------------------------------------------------
// tb_enigma_feeder
//   Directed stimulus for enigma_feeder. A session-level reference model
//   (entries loaded, gap cycles elapsed, message finished) predicts every
//   DUT output each cycle; logs of the DUT's load and encrypt traffic are
//   also compared against hand-written expected sequences.
// ----------------------------------------------------------------------------
module tb_enigma_feeder;

  localparam int TABLE_DEPTH = 64;
  localparam int DATA_W      = 6;
  localparam int IDX_W       = 8;
  localparam int GAP_CYCLES  = 1;
  localparam int PT_LEN      = 23;

  logic              clk = 1'b0;
  logic              srst = 1'b1;
  logic              start = 1'b0;
  logic              mode_in = 1'b0;
  logic              load;
  logic [IDX_W-1:0]  load_idx;
  logic [DATA_W-1:0] code_out;
  logic              encrypt;
  logic              crypt_mode;
  logic              busy;
  logic              done;
  logic              perm_err;

  enigma_feeder_if #(.DATA_W(DATA_W)) up ();

  enigma_feeder #(
    .TABLE_DEPTH (TABLE_DEPTH),
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .start      (start),
    .mode_in    (mode_in),
    .up         (up),
    .load       (load),
    .load_idx   (load_idx),
    .code_out   (code_out),
    .encrypt    (encrypt),
    .crypt_mode (crypt_mode),
    .busy       (busy),
    .done       (done),
    .perm_err   (perm_err)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Session-level reference model
  // --------------------------------------------------------------------------
  bit        model_on = 1'b0;
  bit        m_active;
  int        m_entries;
  int        m_gap_n;
  bit        m_finishing;
  bit        m_load;
  int        m_idx;
  int        m_code;
  bit        m_enc;
  bit        m_mode;
  bit        m_perm;
  bit [63:0] m_seen;

  function automatic bit m_loading();
    return m_active && !m_finishing && (m_entries < TABLE_DEPTH);
  endfunction

  function automatic bit m_in_gap();
    return m_active && (m_entries == TABLE_DEPTH) && (m_gap_n < GAP_CYCLES);
  endfunction

  function automatic bit m_crypting();
    return m_active && !m_finishing && (m_entries == TABLE_DEPTH) &&
           (m_gap_n == GAP_CYCLES);
  endfunction

  task automatic model_step();
    bit loading, in_gap, crypting, beat;
    int d;
    if (srst) begin
      model_on    = 1'b1;
      m_active    = 1'b0;
      m_entries   = 0;
      m_gap_n     = 0;
      m_finishing = 1'b0;
      m_load      = 1'b0;
      m_idx       = 0;
      m_code      = 0;
      m_enc       = 1'b0;
      m_mode      = 1'b0;
      m_perm      = 1'b0;
      m_seen      = '0;
      return;
    end
    if (!model_on) return;
    loading  = m_loading();
    in_gap   = m_in_gap();
    crypting = m_crypting();
    beat     = up.in_valid && (loading || crypting);
    d        = int'(up.in_data);
    m_load   = loading && beat;
    m_enc    = crypting && beat;

    if (m_finishing) begin
      m_active    = 1'b0;
      m_finishing = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active  = 1'b1;
        m_mode    = mode_in;
        m_entries = 0;
        m_gap_n   = 0;
        m_seen    = '0;
        m_perm    = 1'b0;
      end
    end else if (loading && beat) begin
`ifdef ROTOR_CHECK_EN
      if (m_seen[d]) m_perm = 1'b1;
      m_seen[d] = 1'b1;
`endif
      m_idx  = m_entries;
      m_code = d;
      m_entries++;
`ifdef ROTOR_CHECK_EN
      if (m_entries == TABLE_DEPTH && m_seen != 64'hFFFF_FFFF_FFFF_FFFF) m_perm = 1'b1;
`endif
    end else if (in_gap) begin
      m_gap_n++;
    end else if (crypting && beat) begin
      m_code = d;
      if (up.in_last) m_finishing = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // --------------------------------------------------------------------------
  // Per-cycle compare and traffic logs (sampled on the falling edge)
  // --------------------------------------------------------------------------
  int ld_idx_log[$];
  int ld_code_log[$];
  int enc_log[$];
  int done_cnt;
  int cyc_n = 0;
  int first_load, last_load, first_enc, last_enc;

  task automatic clear_logs();
    ld_idx_log.delete();
    ld_code_log.delete();
    enc_log.delete();
    done_cnt   = 0;
    first_load = -1;
    last_load  = -1;
    first_enc  = -1;
    last_enc   = -1;
  endtask

  initial forever begin
    @(negedge clk);
    cyc_n++;
    if (model_on) begin
      check("load",       load,        m_load);
      check("load_idx",   load_idx,    m_idx);
      check("code_out",   code_out,    m_code);
      check("encrypt",    encrypt,     m_enc);
      check("crypt_mode", crypt_mode,  m_mode);
      check("busy",       busy,        m_active);
      check("done",       done,        m_finishing);
      check("in_ready",   up.in_ready, m_loading() || m_crypting());
      check("perm_err",   perm_err,    m_perm);
      if (load === 1'b1) begin
        ld_idx_log.push_back(int'(load_idx));
        ld_code_log.push_back(int'(code_out));
        if (first_load < 0) first_load = cyc_n;
        last_load = cyc_n;
      end
      if (encrypt === 1'b1) begin
        enc_log.push_back(int'(code_out));
        if (first_enc < 0) first_enc = cyc_n;
        last_enc = cyc_n;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] txq[$];
  logic [DATA_W-1:0] pt[PT_LEN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit m);
    start   = 1'b1;
    mode_in = m;
    tick();
    start   = 1'b0;
    mode_in = 1'b0;
  endtask

  task automatic fill_identity();
    txq.delete();
    for (int i = 0; i < TABLE_DEPTH; i++) txq.push_back(DATA_W'(i));
  endtask

  task automatic fill_pt();
    txq.delete();
    for (int i = 0; i < PT_LEN; i++) txq.push_back(pt[i]);
  endtask

  // Presents txq in order; optional bubble run before element bubble_at,
  // optional start pulse on stream cycle start_at, optional junk in_last.
  task automatic send_stream(input int bubble_at, input int bubble_len,
                             input bit mark_last, input int start_at,
                             input bit noise_last);
    int k   = 0;
    int cyc = 0;
    int bub = bubble_len;
    bit acc;
    while (k < txq.size() && cyc < 500) begin
      start = (cyc == start_at);
      if (k == bubble_at && bub > 0) begin
        up.in_valid = 1'b0;
        up.in_last  = 1'b0;
        bub--;
      end else begin
        up.in_valid = 1'b1;
        up.in_data  = txq[k];
        up.in_last  = mark_last ? (k == txq.size() - 1) : (noise_last && (k % 7 == 3));
      end
      acc = up.in_valid && up.in_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    start       = 1'b0;
    up.in_valid = 1'b0;
    up.in_last  = 1'b0;
    if (k < txq.size()) begin
      n_vec++;
      n_bad++;
      $display("FAIL stream_timeout: got %0d beats accepted, expected %0d", k, txq.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load"},     load,        1'b0);
    check({tag, "_load_idx"}, load_idx,    '0);
    check({tag, "_code_out"}, code_out,    '0);
    check({tag, "_encrypt"},  encrypt,     1'b0);
    check({tag, "_mode"},     crypt_mode,  1'b0);
    check({tag, "_busy"},     busy,        1'b0);
    check({tag, "_done"},     done,        1'b0);
    check({tag, "_ready"},    up.in_ready, 1'b0);
    check({tag, "_perm"},     perm_err,    1'b0);
  endtask

  task automatic check_table_log(input string tag, input int dup_at);
    check({tag, "_load_count"}, ld_idx_log.size(), TABLE_DEPTH);
    for (int i = 0; i < ld_idx_log.size() && i < TABLE_DEPTH; i++) begin
      check({tag, "_idx_seq"},  ld_idx_log[i],  i);
      check({tag, "_code_seq"}, ld_code_log[i], (i == dup_at) ? 5 : i);
    end
  endtask

  task automatic check_pt_log(input string tag);
    check({tag, "_enc_count"}, enc_log.size(), PT_LEN);
    for (int i = 0; i < enc_log.size() && i < PT_LEN; i++) begin
      check({tag, "_enc_seq"}, enc_log[i], int'(pt[i]));
    end
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  // --------------------------------------------------------------------------
  // Directed tests
  // --------------------------------------------------------------------------
  initial begin
    pt = '{6'h07, 6'h04, 6'h0B, 6'h0B, 6'h0E, 6'h3F, 6'h16, 6'h0E,
           6'h11, 6'h0B, 6'h03, 6'h00, 6'h01, 6'h02, 6'h20, 6'h21,
           6'h2A, 6'h15, 6'h30, 6'h3E, 6'h19, 6'h05, 6'h1C};
    up.in_valid = 1'b0;
    up.in_data  = '0;
    up.in_last  = 1'b0;
    clear_logs();

    // Reset state
    srst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    srst = 1'b0;
    tick();

    // Reset in the middle of a table load
    do_start(1'b1);
    txq.delete();
    for (int i = 0; i < 10; i++) txq.push_back(DATA_W'(i + 40));
    send_stream(-1, 0, 1'b0, -1, 1'b0);
    srst = 1'b1;
    tick();
    check_all_zero("midload_rst");
    srst = 1'b0;
    tick();

    // Back-to-back identity table, then a 23-symbol message
    clear_logs();
    do_start(1'b1);
    fill_identity();
    send_stream(-1, 0, 1'b0, -1, 1'b0);
    fill_pt();
    send_stream(-1, 0, 1'b1, -1, 1'b0);
    repeat (3) tick();
    check_table_log("b2b", -1);
    check("b2b_crypt_mode", crypt_mode, 1'b1);
    check("b2b_gap_len", first_enc - last_load - 1, GAP_CYCLES);
    check("b2b_load_span", last_load - first_load + 1, TABLE_DEPTH);
    check_pt_log("b2b");
    check("b2b_busy_after", busy, 1'b0);
    check("b2b_ready_after", up.in_ready, 1'b0);
    check("b2b_perm_ok", perm_err, 1'b0);

    // Bubbles: 3 cycles after entry 20, 2 cycles inside the message;
    // junk in_last during the table load must be ignored.
    clear_logs();
    do_start(1'b0);
    fill_identity();
    send_stream(21, 3, 1'b0, -1, 1'b1);
    fill_pt();
    send_stream(5, 2, 1'b1, -1, 1'b0);
    repeat (3) tick();
    check_table_log("bub", -1);
    check("bub_load_span", last_load - first_load + 1, TABLE_DEPTH + 3);
    check("bub_enc_span", last_enc - first_enc + 1, PT_LEN + 2);
    check("bub_crypt_mode", crypt_mode, 1'b0);
    check_pt_log("bub");

    // Start pulsed during CRYPT is ignored
    clear_logs();
    do_start(1'b1);
    fill_identity();
    send_stream(-1, 0, 1'b0, -1, 1'b0);
    fill_pt();
    send_stream(-1, 0, 1'b1, 4, 1'b0);
    repeat (3) tick();
    check_pt_log("ign");
    check("ign_enc_span", last_enc - first_enc + 1, PT_LEN);
    check("ign_busy_after", busy, 1'b0);

    // Table with 0x05 at index 9 (0x09 missing)
    clear_logs();
    do_start(1'b0);
    fill_identity();
    txq[9] = 6'h05;
    send_stream(-1, 0, 1'b0, -1, 1'b0);
    txq.delete();
    txq.push_back(6'h01);
    txq.push_back(6'h02);
    txq.push_back(6'h03);
    send_stream(-1, 0, 1'b1, -1, 1'b0);
    repeat (3) tick();
    check_table_log("dup", 9);
`ifdef ROTOR_CHECK_EN
    check("dup_perm_err", perm_err, 1'b1);
`else
    check("dup_perm_err", perm_err, 1'b0);
`endif
    check("dup_enc_count", enc_log.size(), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule : tb_enigma_feeder
